// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, requester ids and the default burst length.
package mem_arb_pkg;

    localparam int DEF_BURST_LEN = 8;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE,
        P,
        D,
        W
    } req_id_t;

endpackage

// File: rtl/arb_select.sv
// Requester selection: writeback always wins; fill policy is fixed d > p, or p/d alternation
// when ARB_ROUND_ROBIN_EN is defined (the last-fill flag only exists in that build).
module arb_select
    import mem_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_upd,
    input  logic    i_p_req,
    input  logic    i_d_req,
    input  logic    i_w_req,
    output req_id_t o_id
);

    req_id_t w_fill;

`ifdef ARB_ROUND_ROBIN_EN
    // Reset to "p last" so d wins the first tie.
    logic r_last_d;

    always_comb begin
        w_fill = NONE;
        if (i_p_req && i_d_req) w_fill = r_last_d ? P : D;
        else if (i_d_req)       w_fill = D;
        else if (i_p_req)       w_fill = P;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_last_d <= 1'b0;
        else if (i_upd && (o_id == P || o_id == D))
            r_last_d <= (o_id == D);
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, i_upd};

    always_comb begin
        w_fill = NONE;
        if (i_d_req)      w_fill = D;
        else if (i_p_req) w_fill = P;
    end
`endif

    assign o_id = i_w_req ? W : w_fill;

endmodule

// File: rtl/mem_arbiter.sv
// Three-way burst arbiter (program fill, data fill, writeback) in front of an SDRAM controller.
// Fill policy is selected by ARB_ROUND_ROBIN_EN inside arb_select.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [15:0]       w_wdata,
    output logic              p_beat,
    output logic              d_beat,
    output logic              w_beat,
    output logic              p_done,
    output logic              d_done,
    output logic              w_done,
    output logic [15:0]       rdata,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata
);

    localparam int              CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

    arb_state_t        r_state;
    req_id_t           r_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;

    req_id_t           w_pick;
    logic              w_upd;
    logic [ADDR_W-1:0] w_grant_addr;
    logic              w_ack;

    assign w_upd = (r_state == IDLE) && (w_pick != NONE);

    arb_select u_sel (
        .clk     (clk),
        .rst     (rst),
        .i_upd   (w_upd),
        .i_p_req (p_req),
        .i_d_req (d_req),
        .i_w_req (w_req),
        .o_id    (w_pick)
    );

    always_comb begin
        w_grant_addr = '0;
        case (w_pick)
            P:       w_grant_addr = p_addr;
            D:       w_grant_addr = d_addr;
            W:       w_grant_addr = w_addr;
            default: w_grant_addr = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_grant <= NONE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_upd) begin
                        r_state <= XFER;
                        r_grant <= w_pick;
                        r_cnt   <= '0;
                        r_we    <= (w_pick == W);
                        r_addr  <= w_grant_addr;
                    end
                end
                XFER: begin
                    // Counter wraps naturally since BURST_LEN is a power of two.
                    if (mem_ack) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST) r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_grant <= NONE;
                    r_we    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req   = (r_state == XFER);
    assign busy      = (r_state != IDLE);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = (r_grant == W) ? w_wdata : 16'h0;
    assign rdata     = mem_rdata;

    assign w_ack  = mem_req && mem_ack;
    assign p_beat = w_ack && (r_grant == P);
    assign d_beat = w_ack && (r_grant == D);
    assign w_beat = w_ack && (r_grant == W);
    assign p_done = (r_state == DONE) && (r_grant == P);
    assign d_done = (r_state == DONE) && (r_grant == D);
    assign w_done = (r_state == DONE) && (r_grant == W);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a burst-level reference model (owner + beats left).
module tb_mem_arbiter;

    localparam int BL = 8;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          p_req, d_req, w_req, mem_ack;
    logic [AW-1:0] p_addr, d_addr, w_addr;
    logic [15:0]   w_wdata, mem_rdata;
    logic          p_beat, d_beat, w_beat, p_done, d_done, w_done;
    logic [15:0]   rdata, mem_wdata;
    logic          busy, mem_req, mem_we;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_addr(p_addr),
        .d_req(d_req), .d_addr(d_addr),
        .w_req(w_req), .w_addr(w_addr), .w_wdata(w_wdata),
        .p_beat(p_beat), .d_beat(d_beat), .w_beat(w_beat),
        .p_done(p_done), .d_done(d_done), .w_done(w_done),
        .rdata(rdata), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the bus, how many beats remain, and whether a done pulse is due.
    int            m_owner;   // 0 none, 1 p, 2 d, 3 w
    int            m_left;
    bit            m_active;
    bit            m_done;
    bit            m_we;
    bit            m_last_d;
    logic [AW-1:0] m_addr;
    int            grants_p, grants_d;

    task automatic compare();
        logic [7:0] exp_s;
        exp_s = {m_active && mem_ack && m_owner == 1,
                 m_active && mem_ack && m_owner == 2,
                 m_active && mem_ack && m_owner == 3,
                 m_done && m_owner == 1,
                 m_done && m_owner == 2,
                 m_done && m_owner == 3,
                 m_active,
                 m_active || m_done};
        check("strobes", {56'h0, p_beat, d_beat, w_beat, p_done, d_done, w_done, mem_req, busy},
              {56'h0, exp_s});
        check("wdata", {48'h0, mem_wdata}, {48'h0, (m_owner == 3) ? w_wdata : 16'h0});
        check("rdata", {48'h0, rdata}, {48'h0, mem_rdata});
        if (m_active) begin
            check("addr", {32'h0, mem_addr}, {32'h0, m_addr});
            check("we", {63'h0, mem_we}, {63'h0, m_we});
        end
    endtask

    task automatic model_step();
        int pick;
        if (!rst) begin
            m_active = 0; m_done = 0; m_owner = 0; m_last_d = 0;
        end else if (m_active) begin
            if (mem_ack) begin
                m_left--;
                if (m_left == 0) begin m_active = 0; m_done = 1; end
            end
        end else if (m_done) begin
            m_done = 0; m_owner = 0;
        end else begin
            pick = 0;
            if (w_req) pick = 3;
            else if (p_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                pick = m_last_d ? 1 : 2;
`else
                pick = 2;
`endif
            end
            else if (d_req) pick = 2;
            else if (p_req) pick = 1;
            if (pick != 0) begin
                m_active = 1;
                m_left   = BL;
                m_owner  = pick;
                m_we     = (pick == 3);
                m_addr   = (pick == 1) ? p_addr : (pick == 2) ? d_addr : w_addr;
                if (pick == 1) grants_p++;
                if (pick == 2) grants_d++;
                if (pick != 3) m_last_d = (pick == 2);
            end
        end
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic tick();
        #1;
        compare();
        model_step();
        @(negedge clk);
    endtask

    task automatic rand_data();
        p_addr    = $urandom;
        d_addr    = $urandom;
        w_addr    = $urandom;
        w_wdata   = 16'($urandom);
        mem_rdata = 16'($urandom);
    endtask

    // mode: 0 p only/ack 1, 1 w+d/ack 1, 2 p+d held/random ack, 3 p only/toggling ack, 4 random
    task automatic run_phase(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            rand_data();
            rst = 1'b1;
            case (mode)
                0: begin p_req = 1; d_req = 0; w_req = 0; mem_ack = 1; end
                1: begin p_req = 0; d_req = 1; w_req = 1; mem_ack = 1; w_addr = 32'h100; end
                2: begin p_req = 1; d_req = 1; w_req = 0; mem_ack = ($urandom_range(0, 3) != 0); end
                3: begin p_req = 1; d_req = 0; w_req = 0; mem_ack = (i % 2 == 0); end
                default: begin
                    p_req   = ($urandom_range(0, 9) < 4);
                    d_req   = ($urandom_range(0, 9) < 4);
                    w_req   = ($urandom_range(0, 9) < 3);
                    mem_ack = ($urandom_range(0, 9) < 7);
                    rst     = ($urandom_range(0, 149) != 0);
                end
            endcase
            tick();
        end
    endtask

    initial begin
        rst = 1'b0; p_req = 0; d_req = 0; w_req = 0; mem_ack = 0;
        rand_data();
        m_owner = 0; m_left = 0; m_active = 0; m_done = 0; m_we = 0; m_last_d = 0; m_addr = '0;
        grants_p = 0; grants_d = 0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            rand_data();
            rst = 1'b0; p_req = 1; d_req = 1; w_req = 1; mem_ack = 1;
            tick();
        end
        check("rst_addr", {32'h0, mem_addr}, 64'h0);
        check("rst_we", {63'h0, mem_we}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);

        run_phase(30, 0);
        run_phase(40, 1);
        run_phase(5, 4);
        grants_p = 0; grants_d = 0;
        run_phase(120, 2);
`ifdef ARB_ROUND_ROBIN_EN
        check("rr_balance", {63'h0, (grants_p > 0 && grants_d > 0 &&
              (grants_p - grants_d <= 1) && (grants_d - grants_p <= 1))}, 64'h1);
`else
        check("fixed_starve_p", {32'h0, 32'(grants_p)}, 64'h0);
`endif
        run_phase(40, 3);

        // reset after the third beat of a p burst
        p_req = 0; d_req = 0; w_req = 0; rst = 1;
        for (int i = 0; i < 4; i++) begin rand_data(); tick(); end
        for (int i = 0; i < 4; i++) begin
            rand_data(); rst = 1; p_req = 1; mem_ack = 1; tick();
        end
        rand_data(); rst = 0; tick();
        check("midrst_req", {63'h0, mem_req}, 64'h0);
        check("midrst_busy", {63'h0, busy}, 64'h0);
        check("midrst_done", {63'h0, p_done}, 64'h0);
        run_phase(30, 0);

        run_phase(2500, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 8: words per burst, power of two, 2..64.
REQ-002 Parameter ADDR_W, default 32: memory address width.
REQ-003 Clocking: one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 p_req  in  1  program-cache fill request, level.
REQ-007 p_addr  in  ADDR_W  program fill burst base address.
REQ-008 d_req  in  1  data-cache fill request, level.
REQ-009 d_addr  in  ADDR_W  data fill burst base address.
REQ-010 w_req  in  1  data-cache writeback request, level.
REQ-011 w_addr  in  ADDR_W  writeback burst base address.
REQ-012 w_wdata  in  16  writeback word for current beat.
REQ-013 p_beat, d_beat, w_beat  out  1 each  beat strobe to owning requester: read word valid, or write word consumed.
REQ-014 p_done, d_done, w_done  out  1 each  one-cycle burst-complete pulse.
REQ-015 rdata  out  16  mem_rdata broadcast to all requesters.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 mem_req  out  1  burst active toward SDRAM controller.
REQ-018 mem_we  out  1  1 = write burst, 0 = read burst.
REQ-019 mem_addr  out  ADDR_W  granted base address, held for the whole burst.
REQ-020 mem_wdata  out  16  w_wdata when writeback is granted, else 0.
REQ-021 mem_ack  in  1  per-beat accept; read data is valid on mem_rdata in the same cycle.
REQ-022 mem_rdata  in  16  SDRAM read word.

Function
REQ-023 States: IDLE, XFER, DONE.
REQ-024 IDLE: if any request is high, register grant, mem_addr and mem_we, clear beat counter, go to XFER; otherwise stay in IDLE.
REQ-025 Latency: request high in cycle N with the arbiter in IDLE gives mem_req high in cycle N+1.
REQ-026 mem_req = (state == XFER), decoded from the state register.
REQ-027 XFER: each cycle with mem_ack high asserts the granted X_beat combinationally and increments the beat counter modulo BURST_LEN.
REQ-028 Last beat: counter == BURST_LEN-1 with mem_ack high moves the arbiter to DONE, so mem_req is low the next cycle.
REQ-029 DONE lasts exactly one cycle: the granted X_done is high, then the arbiter returns to IDLE.
REQ-030 Requester obligation: X_req is low in the cycle after X_done; if it is not, IDLE grants a new burst.
REQ-031 Requests, and changes to them, arriving during XFER or DONE are ignored; bursts are never aborted.
REQ-032 Requester address and data change only between bursts; mem_addr is latched at grant.
REQ-033 Beats not granted to a requester keep its X_beat low; rdata is unqualified outside beats.
REQ-034 Writeback has the highest priority, so a dirty-line eviction precedes the fill that replaces it.
REQ-035 With all three requests high at once, w is granted.

Reset
REQ-036 rst low at a clock edge: state IDLE, counter 0, grant none, mem_req/mem_we/all beat/done/busy 0, mem_addr 0.
REQ-037 Reset mid-burst abandons the burst with no done pulse; mem_req is low from the next cycle.

Configuration
REQ-038 Macro ARB_ROUND_ROBIN_EN selects the fill-arbitration policy.
REQ-039 Defined: p and d fills alternate via a last-fill flag; the flag is reset to "p last" so d wins the first tie; w keeps absolute priority.
REQ-040 Undefined: fixed priority w > d > p; no flag register exists.

Structure
REQ-041 Package mem_arb_pkg holds the state enum (IDLE/XFER/DONE), the requester-id enum (NONE/P/D/W) and the default BURST_LEN.
REQ-042 Sub-module arb_select: combinational priority select from the requests and the last-fill flag to a requester id; it holds the only macro-dependent logic.

Verification
REQ-043 p_req only, BURST_LEN 8, mem_ack always 1 -> mem_req cycles 1..8, mem_we 0, 8 p_beat, p_done in cycle 9, busy low in cycle 10.
REQ-044 w_req and d_req both high, w_addr=0x100 -> writeback burst first (mem_we 1, mem_addr 0x100, mem_wdata tracks w_wdata), then d burst.
REQ-045 p_req and d_req held continuously -> with macro defined, grants alternate D,P,D,P; without it, D repeats and P starves.
REQ-046 mem_ack toggling 1,0,1,0 -> exactly 8 beats, done after the 8th ack, mem_req never drops mid-burst.
REQ-047 rst low after the 3rd beat -> next cycle mem_req 0, busy 0, no done pulse; a fresh request restarts with the counter at 0.
REQ-048 p_req dropped mid-burst -> burst completes and p_done still pulses.
